// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - fetch-side and decode-side handshakes of the instruction queue
// slave is the queue; master is the fetch/decode environment around it.
interface instr_queue_if #(
  parameter type T = logic [31:0]
);
  T     instr_from_fetch;
  T     pc_from_fetch;
  logic fetch_valid;
  logic fetch_ready;
  T     instr_to_decode;
  T     pc_to_decode;
  logic decode_valid;
  logic decode_ready;

  modport slave (
    input  instr_from_fetch,
    input  pc_from_fetch,
    input  fetch_valid,
    output fetch_ready,
    output instr_to_decode,
    output pc_to_decode,
    output decode_valid,
    input  decode_ready
  );

  modport master (
    output instr_from_fetch,
    output pc_from_fetch,
    output fetch_valid,
    input  fetch_ready,
    input  instr_to_decode,
    input  pc_to_decode,
    input  decode_valid,
    output decode_ready
  );
endinterface

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-decode decoupling FIFO of {instr, pc} pairs with branch flush
// Outputs depend on registered state only: no bypass when empty, no push into a full queue.
module instr_queue #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   take_branch,
  instr_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  T              instr_mem [DEPTH];
  T              pc_mem    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          not_full;
  logic          not_empty;
  logic          push;
  logic          pop;

  assign not_full  = (count != FULL_COUNT);
  assign not_empty = (count != '0);

  // A flush or reset in the same cycle swallows any offered handshake.
  assign push = bus.fetch_valid && not_full && !take_branch && !reset;
  assign pop  = bus.decode_ready && not_empty && !take_branch && !reset;

  assign bus.fetch_ready     = not_full;
  assign bus.decode_valid    = not_empty;
  assign bus.instr_to_decode = not_empty ? instr_mem[rd_ptr] : '0;
  assign bus.pc_to_decode    = not_empty ? pc_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.instr_from_fetch;
      pc_mem[wr_ptr]    <= bus.pc_from_fetch;
    end
  end

  // Pointers are log2(DEPTH) wide, so the increment wraps DEPTH-1 -> 0 on its own.
  always_ff @(posedge clk) begin
    if (reset || take_branch) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed and randomized checks of instr_queue against a queue-based model
module tb_instr_queue;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  typedef logic [31:0] word_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          take_branch;
  logic [CW-1:0] count;

  instr_queue_if #(.T(word_t)) bus ();

  instr_queue #(.T(word_t), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .take_branch (take_branch),
    .bus         (bus),
    .count       (count)
  );

  always #5 clk = ~clk;

  word_t imem [128];
  word_t mq_pc[$];
  word_t mq_instr[$];
  int    checks = 0;
  int    errors = 0;

  function automatic word_t instr_of(input word_t pc);
    return imem[pc[8:2]];
  endfunction

  task automatic drive(input logic fv, input word_t pc, input logic dr, input logic br, input logic rs);
    bus.fetch_valid      = fv;
    bus.pc_from_fetch    = pc;
    bus.instr_from_fetch = instr_of(pc);
    bus.decode_ready     = dr;
    take_branch          = br;
    reset                = rs;
  endtask

  // Advance one clock; the model applies the FIFO rules to the inputs that were present at the edge.
  task automatic tick();
    bit    do_push;
    bit    do_pop;
    word_t in_pc;
    word_t in_instr;
    do_push  = bus.fetch_valid && (mq_pc.size() < DEPTH) && !take_branch && !reset;
    do_pop   = bus.decode_ready && (mq_pc.size() > 0) && !take_branch && !reset;
    in_pc    = bus.pc_from_fetch;
    in_instr = bus.instr_from_fetch;
    @(posedge clk);
    #1;
    if (reset || take_branch) begin
      mq_pc.delete();
      mq_instr.delete();
    end else begin
      if (do_pop) begin
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
      end
      if (do_push) begin
        mq_pc.push_back(in_pc);
        mq_instr.push_back(in_instr);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (bus.decode_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b want 0", bus.decode_valid); end
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fready got %b want 1", bus.fetch_ready); end
    checks++; if (bus.pc_to_decode !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.pc_to_decode); end
    checks++; if (bus.instr_to_decode !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.instr_to_decode); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, word_t'(4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, DEPTH); end
    checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_fready got %b want 0", bus.fetch_ready); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (bus.pc_to_decode !== word_t'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d] got %h want %h", i, bus.pc_to_decode, 4 * i); end
      checks++; if (bus.instr_to_decode !== imem[i]) begin errors++; $display("FAIL drain_instr[%0d] got %h want %h", i, bus.instr_to_decode, imem[i]); end
      checks++; if (count !== CW'(DEPTH - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, DEPTH - i); end
      tick();
    end
    checks++; if (bus.decode_valid !== 1'b0) begin errors++; $display("FAIL drain_dvalid got %b want 0", bus.decode_valid); end
    checks++; if (count !== 0) begin errors++; $display("FAIL drain_count_end got %0d want 0", count); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full_backpressure();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, word_t'(4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL full_fready got %b want 0", bus.fetch_ready); end
    tick();
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== CW'(DEPTH - 1)) begin errors++; $display("FAIL full_pop_count got %0d want %0d", count, DEPTH - 1); end
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL full_pop_fready got %b want 1", bus.fetch_ready); end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_accept_count got %0d want %0d", count, DEPTH); end
    checks++; if (bus.pc_to_decode !== 32'h4) begin errors++; $display("FAIL full_head_pc got %h want 4", bus.pc_to_decode); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (bus.pc_to_decode !== word_t'(4 * i)) begin errors++; $display("FAIL full_drain_pc[%0d] got %h want %h", i, bus.pc_to_decode, 4 * i); end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_streaming();
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.decode_valid !== 1'b0) begin errors++; $display("FAIL stream_bypass dvalid got %b want 0", bus.decode_valid); end
    tick();
    for (int k = 1; k < 20; k++) begin
      drive(1'b1, word_t'(32'h40 + 4 * k), 1'b1, 1'b0, 1'b0);
      checks++; if (count !== 1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", k, count); end
      checks++; if (bus.pc_to_decode !== word_t'(32'h40 + 4 * (k - 1))) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", k, bus.pc_to_decode, 32'h40 + 4 * (k - 1)); end
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (count !== 0) begin errors++; $display("FAIL stream_end_count got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, word_t'(4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h14, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    checks++; if (bus.decode_valid !== 1'b0) begin errors++; $display("FAIL flush_dvalid got %b want 0", bus.decode_valid); end
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_fready got %b want 1", bus.fetch_ready); end
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.pc_to_decode !== 32'h100) begin errors++; $display("FAIL flush_new_pc got %h want 100", bus.pc_to_decode); end
    checks++; if (bus.instr_to_decode !== imem[64]) begin errors++; $display("FAIL flush_new_instr got %h want %h", bus.instr_to_decode, imem[64]); end
    checks++; if (count !== 1) begin errors++; $display("FAIL flush_new_count got %0d want 1", count); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, word_t'(32'h200 + 4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.decode_valid !== 1'b1) begin errors++; $display("FAIL stall_dvalid[%0d] got %b want 1", k, bus.decode_valid); end
      checks++; if (bus.pc_to_decode !== 32'h200) begin errors++; $display("FAIL stall_pc[%0d] got %h want 200", k, bus.pc_to_decode); end
      checks++; if (bus.instr_to_decode !== instr_of(32'h200)) begin errors++; $display("FAIL stall_instr[%0d] got %h want %h", k, bus.instr_to_decode, instr_of(32'h200)); end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, word_t'(32'h300 + 4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h318, 1'b1, 1'b0, 1'b1);
      tick();
      checks++; if (bus.decode_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_dvalid[%0d] got %b want 0", k, bus.decode_valid); end
      checks++; if (count !== 0) begin errors++; $display("FAIL rst_mid_count[%0d] got %0d want 0", k, count); end
      checks++; if (bus.pc_to_decode !== 32'h0 || bus.instr_to_decode !== 32'h0) begin errors++; $display("FAIL rst_mid_out[%0d] got %h/%h want 0/0", k, bus.pc_to_decode, bus.instr_to_decode); end
    end
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.pc_to_decode !== 32'h0 || bus.instr_to_decode !== imem[0]) begin errors++; $display("FAIL rst_first got %h/%h want 0/%h", bus.pc_to_decode, bus.instr_to_decode, imem[0]); end
    checks++; if (count !== 1) begin errors++; $display("FAIL rst_first_count got %0d want 1", count); end
    tick();
    checks++; if (bus.decode_valid !== 1'b0) begin errors++; $display("FAIL rst_no_old dvalid got %b want 0", bus.decode_valid); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    word_t exp_pc;
    word_t exp_instr;
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 9) < 7), word_t'($urandom_range(0, 127) * 4),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) < 2));
      exp_pc    = (mq_pc.size() > 0) ? mq_pc[0] : 32'h0;
      exp_instr = (mq_instr.size() > 0) ? mq_instr[0] : 32'h0;
      checks++; if (count !== CW'(mq_pc.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, count, mq_pc.size()); end
      checks++; if (bus.decode_valid !== (mq_pc.size() != 0)) begin errors++; $display("FAIL rnd_dvalid[%0d] got %b", n, bus.decode_valid); end
      checks++; if (bus.fetch_ready !== (mq_pc.size() != DEPTH)) begin errors++; $display("FAIL rnd_fready[%0d] got %b", n, bus.fetch_ready); end
      checks++; if (bus.pc_to_decode !== exp_pc || bus.instr_to_decode !== exp_instr) begin errors++; $display("FAIL rnd_head[%0d] got %h/%h want %h/%h", n, bus.pc_to_decode, bus.instr_to_decode, exp_pc, exp_instr); end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      imem[i] = $urandom;
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_fill_drain();
    test_full_backpressure();
    test_streaming();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
